// File: rtl/seq_udiv_pkg.sv
// Shared definitions for the sequential unsigned divider: FSM state encoding and default width.
package seq_udiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_W = 8;

endpackage

// File: rtl/seq_udiv_if.sv
// Request/response handshake bundle for seq_udiv; master is the requester, slave is the divider.
interface seq_udiv_if
    import seq_udiv_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) ();

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_dividend;
    logic [W-1:0] in_divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_quotient;
    logic [W-1:0] out_remainder;
    logic         out_div_zero;

    modport master (
        output in_valid, in_dividend, in_divisor, out_ready,
        input  in_ready, out_valid, out_quotient, out_remainder, out_div_zero
    );

    modport slave (
        input  in_valid, in_dividend, in_divisor, out_ready,
        output in_ready, out_valid, out_quotient, out_remainder, out_div_zero
    );

endinterface

// File: rtl/seq_udiv_ripple_sub.sv
// Ripple-borrow subtractor built from full-subtractor cells; borrow-in is tied to zero.
module ripple_sub
    import seq_udiv_pkg::*;
#(
    parameter int unsigned N = DEFAULT_W + 1
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow_out
);

    logic [N:0] borrow;

    always_comb begin
        borrow = '0;
        diff   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            diff[i]       = a[i] ^ b[i] ^ borrow[i];
            borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
        end
    end

    assign borrow_out = borrow[N];

endmodule

// File: rtl/seq_udiv.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, W BUSY cycles per operation.
module seq_udiv
    import seq_udiv_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) (
    input logic      clock,
    input logic      reset,
    seq_udiv_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(W) + 1;

    state_t           state;
    logic [W-1:0]     q;
    logic [W-1:0]     r;
    logic [W-1:0]     d;
    logic [CNT_W-1:0] cnt;
    logic             dz;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [W:0]       t;
    logic [W:0]       diff;
    logic             borrow;
    logic             unused_diff_msb;

    // Partial remainder shifted left with the next dividend bit brought in from q.
    assign t = {r, q[W-1]};

    ripple_sub #(.N(W + 1)) u_sub (
        .a          (t),
        .b          ({1'b0, d}),
        .diff       (diff),
        .borrow_out (borrow)
    );

    // When no borrow occurs diff < d, so its top bit is always zero.
    assign unused_diff_msb = diff[W];

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            q           <= '0;
            r           <= '0;
            d           <= '0;
            cnt         <= '0;
            dz          <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        q          <= bus.in_dividend;
                        r          <= '0;
                        d          <= bus.in_divisor;
                        cnt        <= CNT_W'(W - 1);
                        dz         <= (bus.in_divisor == '0);
                        in_ready_q <= 1'b0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    q   <= {q[W-2:0], ~borrow};
                    r   <= borrow ? t[W-1:0] : diff[W-1:0];
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_quotient  = q;
    assign bus.out_remainder = r;
    assign bus.out_div_zero  = dz;

endmodule

// File: tb/tb_seq_udiv.sv
// Self-checking bench for seq_udiv: directed corner cases plus random operands against an arithmetic model.
module tb_seq_udiv;

    localparam int unsigned W = 8;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    seq_udiv_if #(.W(W)) bus ();

    seq_udiv #(.W(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        if (b == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // Present a request and take the accept edge; in_valid drops afterwards.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_valid    = 1'b1;
        bus.in_dividend = a;
        bus.in_divisor  = b;
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Follow an accepted op through latency, optional stall and response handshake.
    task automatic finish(input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
        logic [W-1:0] eq, er;
        logic         ez;
        model(a, b, eq, er, ez);
        bus.out_ready = 1'b0;
        for (int i = 1; i < int'(W); i++) tick();
        check("out_valid_at_w_minus_1", 32'(bus.out_valid), 32'd0);
        check("in_ready_busy", 32'(bus.in_ready), 32'd0);
        tick();
        check("out_valid_at_w", 32'(bus.out_valid), 32'd1);
        check("quotient", 32'(bus.out_quotient), 32'(eq));
        check("remainder", 32'(bus.out_remainder), 32'(er));
        check("div_zero", 32'(bus.out_div_zero), 32'(ez));
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check("stall_quotient", 32'(bus.out_quotient), 32'(eq));
            check("stall_remainder", 32'(bus.out_remainder), 32'(er));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("valid_after_handshake", 32'(bus.out_valid), 32'd0);
        check("in_ready_after_handshake", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_dividend = '0;
        bus.in_divisor  = '0;
        bus.out_ready   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_quotient", 32'(bus.out_quotient), 32'd0);
        check("reset_remainder", 32'(bus.out_remainder), 32'd0);
        check("reset_div_zero", 32'(bus.out_div_zero), 32'd0);

        accept(8'd100, 8'd7);   finish(8'd100, 8'd7, 0);
        accept(8'd255, 8'd1);   finish(8'd255, 8'd1, 0);
        accept(8'd200, 8'd200); finish(8'd200, 8'd200, 0);
        accept(8'd3, 8'd200);   finish(8'd3, 8'd200, 0);
        accept(8'd5, 8'd0);     finish(8'd5, 8'd0, 0);
        accept(8'd100, 8'd7);   finish(8'd100, 8'd7, 5);

        // Reset in the middle of an operation discards it.
        accept(8'd100, 8'd7);
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        check("midreset_in_ready", 32'(bus.in_ready), 32'd1);
        accept(8'd9, 8'd2);     finish(8'd9, 8'd2, 0);

        // A request held during BUSY/DONE waits until the divider is idle again.
        accept(8'd100, 8'd7);
        bus.in_valid    = 1'b1;
        bus.in_dividend = 8'd50;
        bus.in_divisor  = 8'd3;
        finish(8'd100, 8'd7, 2);
        accept(8'd50, 8'd3);    finish(8'd50, 8'd3, 0);

        for (int n = 0; n < 24; n++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
            accept(ra, rb);
            finish(ra, rb, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
